// File: rtl/csr_machine_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// status/interrupt bit positions, cause codes and the read-modify-write helper.
package csr_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csrOp_e;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_SW_BIT    = 3;
  localparam int IRQ_TIMER_BIT = 7;
  localparam int IRQ_EXT_BIT   = 11;

  localparam logic [31:0] MIE_MASK        = 32'h0000_0888;
  localparam logic [31:0] CAUSE_IRQ_SW    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
  localparam logic [31:0] MISA_VALUE      = 32'h4000_0100;

  function automatic logic [31:0] applyOp(input csrOp_e op, input logic [31:0] old,
                                          input logic [31:0] data);
    logic [31:0] res;
    case (op)
      OP_WRITE: res = data;
      OP_SET:   res = old | data;
      OP_CLEAR: res = old & ~data;
      default:  res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_machine_counter.sv
// Free-running counter with independently writable 32-bit halves; a write to
// either half replaces it and holds off that cycle's increment.
module csr_counter #(
  parameter int COUNTER_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        weLo,
  input  logic        weHi,
  input  logic [31:0] di,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [COUNTER_W-1:0] cnt_r;
  logic [63:0]          cntExt_s;
  logic [63:0]          next_s;

  assign cntExt_s = 64'(cnt_r);
  assign lo       = cntExt_s[31:0];
  assign hi       = cntExt_s[63:32];

  // Next-value selection: CSR write beats increment.
  always_comb begin
    next_s = cntExt_s;
    if (weLo || weHi) begin
      if (weLo) next_s[31:0] = di;
      else      next_s[31:0] = cntExt_s[31:0];
      if (weHi) next_s[63:32] = di;
      else      next_s[63:32] = cntExt_s[63:32];
    end else if (inc) begin
      next_s = cntExt_s + 64'd1;
    end else begin
      next_s = cntExt_s;
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_r <= '0;
    else       cnt_r <= next_s[COUNTER_W-1:0];
  end

endmodule

// File: rtl/csr_machine.sv
// Machine-mode CSR unit: CSR read/RMW port, trap/mret status stacking,
// interrupt pending/priority and trap vector computation.
module csr_machine
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter int          COUNTER_W   = 64,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  op,
  input  logic [11:0] a,
  input  logic [31:0] di,
  output logic [31:0] dout,
  output logic        illegal,
  input  logic        retire,
  input  logic        trapEn,
  input  logic [31:0] trapCause,
  input  logic [31:0] trapPc,
  input  logic        mretEn,
  input  logic        irqExt,
  input  logic        irqTimer,
  input  logic        irqSw,
  output logic [31:0] mepcDo,
  output logic [31:0] trapVector,
  output logic        irqPending,
  output logic [31:0] irqCause
);

  localparam logic [1:0] RESET_MODE =
    (MTVEC_RESET[1:0] == 2'b01 && VECTORED_EN) ? 2'b01 : 2'b00;

  csrOp_e      op_s;
  logic        mieBit_r, mpie_r;
  logic [31:0] mieReg_r, mscratch_r, mepc_r, mcause_r;
  logic [29:0] mtvecBase_r;
  logic [1:0]  mtvecMode_r;
  logic [31:0] rdata_s, newVal_s, mip_s, active_s, mstatus_s;
  logic        known_s, readOnly_s, commit_s;
  logic [31:0] cycLo_s, cycHi_s, insLo_s, insHi_s;

  assign op_s      = csrOp_e'(op);
  assign mstatus_s = {19'd0, 2'b11, 3'd0, mpie_r, 3'd0, mieBit_r, 3'd0};
  assign illegal   = (op_s != OP_NONE) && (!known_s || readOnly_s);
  assign commit_s  = (op_s != OP_NONE) && !illegal;
  assign newVal_s  = applyOp(op_s, rdata_s, di);
  assign dout      = rdata_s;
  assign mepcDo    = mepc_r;

  // CSR read mux and address classification.
  always_comb begin
    rdata_s    = 32'h0;
    known_s    = 1'b1;
    readOnly_s = 1'b0;
    case (a)
      ADDR_MSTATUS:   rdata_s = mstatus_s;
      ADDR_MISA:      rdata_s = MISA_VALUE;
      ADDR_MIE:       rdata_s = mieReg_r;
      ADDR_MIP:       rdata_s = mip_s;
      ADDR_MTVEC:     rdata_s = {mtvecBase_r, mtvecMode_r};
      ADDR_MSCRATCH:  rdata_s = mscratch_r;
      ADDR_MEPC:      rdata_s = mepc_r;
      ADDR_MCAUSE:    rdata_s = mcause_r;
      ADDR_MCYCLE:    rdata_s = cycLo_s;
      ADDR_MCYCLEH:   rdata_s = cycHi_s;
      ADDR_MINSTRET:  rdata_s = insLo_s;
      ADDR_MINSTRETH: rdata_s = insHi_s;
      ADDR_CYCLE:     begin rdata_s = cycLo_s; readOnly_s = 1'b1; end
      ADDR_CYCLEH:    begin rdata_s = cycHi_s; readOnly_s = 1'b1; end
      ADDR_INSTRET:   begin rdata_s = insLo_s; readOnly_s = 1'b1; end
      ADDR_INSTRETH:  begin rdata_s = insHi_s; readOnly_s = 1'b1; end
      default:        known_s = 1'b0;
    endcase
  end

  // Interrupt view, pending flag and priority encoding (ext > sw > timer).
  always_comb begin
    mip_s                = 32'h0;
    mip_s[IRQ_EXT_BIT]   = irqExt;
    mip_s[IRQ_TIMER_BIT] = irqTimer;
    mip_s[IRQ_SW_BIT]    = irqSw;
    active_s             = mieReg_r & mip_s;
    irqPending           = mieBit_r && (active_s != 32'h0);
    if (!irqPending)                irqCause = 32'h0;
    else if (active_s[IRQ_EXT_BIT]) irqCause = CAUSE_IRQ_EXT;
    else if (active_s[IRQ_SW_BIT])  irqCause = CAUSE_IRQ_SW;
    else                            irqCause = CAUSE_IRQ_TIMER;
  end

  // Trap target: interrupts add 4*cause in vectored mode.
  always_comb begin
    trapVector = {mtvecBase_r, 2'b00};
    if (mtvecMode_r == 2'b01 && trapCause[31]) trapVector = {mtvecBase_r, 2'b00} + {trapCause[29:0], 2'b00};
    else                                       trapVector = {mtvecBase_r, 2'b00};
  end

  // CSR state; a trap owns mepc/mcause/mstatus over writes and mret.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mieBit_r    <= 1'b0;
      mpie_r      <= 1'b0;
      mieReg_r    <= 32'h0;
      mscratch_r  <= 32'h0;
      mepc_r      <= 32'h0;
      mcause_r    <= 32'h0;
      mtvecBase_r <= MTVEC_RESET[31:2];
      mtvecMode_r <= RESET_MODE;
    end else begin
      if (commit_s && a == ADDR_MTVEC) begin
        mtvecBase_r <= newVal_s[31:2];
        if (newVal_s[1:0] == 2'b00 || (newVal_s[1:0] == 2'b01 && VECTORED_EN))
          mtvecMode_r <= newVal_s[1:0];
      end
      if (commit_s && a == ADDR_MSCRATCH) mscratch_r <= newVal_s;
      if (commit_s && a == ADDR_MIE)      mieReg_r   <= newVal_s & MIE_MASK;
      if (trapEn) begin
        mepc_r   <= {trapPc[31:2], 2'b00};
        mcause_r <= trapCause;
        mpie_r   <= mieBit_r;
        mieBit_r <= 1'b0;
      end else begin
        if (commit_s && a == ADDR_MEPC)   mepc_r   <= {newVal_s[31:2], 2'b00};
        if (commit_s && a == ADDR_MCAUSE) mcause_r <= newVal_s;
        if (mretEn) begin
          mieBit_r <= mpie_r;
          mpie_r   <= 1'b1;
        end else if (commit_s && a == ADDR_MSTATUS) begin
          mieBit_r <= newVal_s[MSTATUS_MIE];
          mpie_r   <= newVal_s[MSTATUS_MPIE];
        end
      end
    end
  end

  csr_counter #(.COUNTER_W(COUNTER_W)) cycleCnt (
    .clk  (clk),
    .reset(reset),
    .inc  (1'b1),
    .weLo (commit_s && a == ADDR_MCYCLE),
    .weHi (commit_s && a == ADDR_MCYCLEH),
    .di   (newVal_s),
    .lo   (cycLo_s),
    .hi   (cycHi_s)
  );

  csr_counter #(.COUNTER_W(COUNTER_W)) instretCnt (
    .clk  (clk),
    .reset(reset),
    .inc  (retire),
    .weLo (commit_s && a == ADDR_MINSTRET),
    .weHi (commit_s && a == ADDR_MINSTRETH),
    .di   (newVal_s),
    .lo   (insLo_s),
    .hi   (insHi_s)
  );

endmodule

// File: tb/tb_csr_machine.sv
// Directed bench for csr_machine: expectations queued as stimulus is applied,
// popped and asserted against DUT outputs.
module tb_csr_machine;
  import csr_pkg::*;

  logic        clk, reset, illegal, retire, trapEn, mretEn;
  logic        irqExt, irqTimer, irqSw, irqPending;
  logic [1:0]  op;
  logic [11:0] a;
  logic [31:0] di, dout, trapCause, trapPc, mepcDo, trapVector, irqCause;

  int total = 0;
  int bad   = 0;
  logic [63:0] cycModel;
  logic [63:0] insModel;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } expEntry_t;
  expEntry_t sb[$];

  csr_machine #(.MTVEC_RESET(32'h0000_2003), .COUNTER_W(64), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .a(a), .di(di), .dout(dout), .illegal(illegal),
    .retire(retire), .trapEn(trapEn), .trapCause(trapCause), .trapPc(trapPc),
    .mretEn(mretEn), .irqExt(irqExt), .irqTimer(irqTimer), .irqSw(irqSw),
    .mepcDo(mepcDo), .trapVector(trapVector), .irqPending(irqPending), .irqCause(irqCause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExp(input string tag, input logic [31:0] exp);
    expEntry_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic checkObs(input logic [31:0] obs);
    expEntry_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    op = OP_NONE;
    a  = addr;
    pushExp(tag, exp);
    #1;
    checkObs(dout);
  endtask

  task automatic tick();
    @(posedge clk);
    cycModel = cycModel + 64'd1;
    if (retire) insModel = insModel + 64'd1;
    #1;
  endtask

  task automatic wr(input logic [1:0] wop, input logic [11:0] addr, input logic [31:0] data);
    op = wop;
    a  = addr;
    di = data;
    tick();
    op = OP_NONE;
  endtask

  initial begin
    reset = 1'b1; op = OP_NONE; a = 12'h0; di = 32'h0; retire = 1'b0;
    trapEn = 1'b0; trapCause = 32'h0; trapPc = 32'h0; mretEn = 1'b0;
    irqExt = 1'b0; irqTimer = 1'b0; irqSw = 1'b0;
    cycModel = 64'd0; insModel = 64'd0;
    #2;
    rd("rst_mstatus", ADDR_MSTATUS, 32'h0000_1800);
    rd("rst_mtvec", ADDR_MTVEC, 32'h0000_2000);
    pushExp("rst_mepcDo", 32'h0); #1; checkObs(mepcDo);
    pushExp("rst_irqPending", 32'h0); #1; checkObs({31'd0, irqPending});
    @(negedge clk);
    reset = 1'b0;

    repeat (5) tick();
    rd("idle_mcycle", ADDR_MCYCLE, 32'd5);
    rd("idle_minstret", ADDR_MINSTRET, 32'd0);
    rd("idle_mstatus", ADDR_MSTATUS, 32'h0000_1800);
    rd("idle_mtvec", ADDR_MTVEC, 32'h0000_2000);
    rd("idle_cycle", ADDR_CYCLE, cycModel[31:0]);

    // Counter write suppresses the increment, then carries into the high half.
    wr(OP_WRITE, ADDR_MCYCLE, 32'hFFFF_FFFF);
    cycModel = 64'h0000_0000_FFFF_FFFF;
    rd("mcycle_written", ADDR_MCYCLE, 32'hFFFF_FFFF);
    tick(); tick();
    rd("mcycle_wrap_lo", ADDR_MCYCLE, 32'h1);
    rd("mcycleh_carry", ADDR_MCYCLEH, 32'h1);
    retire = 1'b1; tick(); tick(); tick(); retire = 1'b0;
    rd("minstret_3", ADDR_MINSTRET, 32'd3);
    rd("instret_shadow", ADDR_INSTRET, insModel[31:0]);
    rd("cycleh_shadow", ADDR_CYCLEH, cycModel[63:32]);

    // Interrupt enable, pending and priority.
    wr(OP_SET, ADDR_MSTATUS, 32'h8);
    rd("mstatus_mie", ADDR_MSTATUS, 32'h0000_1808);
    wr(OP_WRITE, ADDR_MIE, 32'hFFFF_FFFF);
    rd("mie_mask", ADDR_MIE, 32'h0000_0888);
    wr(OP_CLEAR, ADDR_MIE, 32'h8);
    rd("mie_clear", ADDR_MIE, 32'h0000_0880);
    irqTimer = 1'b1;
    pushExp("irq_pend_timer", 32'h1); #1; checkObs({31'd0, irqPending});
    pushExp("irq_cause_timer", 32'h8000_0007); #1; checkObs(irqCause);
    rd("mip_view", ADDR_MIP, 32'h0000_0080);
    irqSw = 1'b1;
    pushExp("irq_cause_sw_masked", 32'h8000_0007); #1; checkObs(irqCause);
    irqExt = 1'b1;
    pushExp("irq_cause_ext", 32'h8000_000B); #1; checkObs(irqCause);
    tick();
    wr(OP_CLEAR, ADDR_MSTATUS, 32'h8);
    pushExp("irq_pend_gated", 32'h0); #1; checkObs({31'd0, irqPending});
    pushExp("irq_cause_none", 32'h0); #1; checkObs(irqCause);
    irqExt = 1'b0; irqTimer = 1'b0; irqSw = 1'b0;
    wr(OP_SET, ADDR_MSTATUS, 32'h8);

    // Vectored trap, status stacking and mret.
    wr(OP_WRITE, ADDR_MTVEC, 32'h0000_1001);
    rd("mtvec_vectored", ADDR_MTVEC, 32'h0000_1001);
    trapCause = 32'h8000_0007;
    pushExp("vec_irq", 32'h0000_101C); #1; checkObs(trapVector);
    trapCause = 32'h0000_0007;
    pushExp("vec_exc", 32'h0000_1000); #1; checkObs(trapVector);
    trapCause = 32'h8000_0007; trapPc = 32'h1234_5676; trapEn = 1'b1;
    tick();
    trapEn = 1'b0;
    rd("trap_mstatus", ADDR_MSTATUS, 32'h0000_1880);
    pushExp("trap_mepcDo", 32'h1234_5674); #1; checkObs(mepcDo);
    rd("trap_mcause", ADDR_MCAUSE, 32'h8000_0007);
    mretEn = 1'b1; tick(); mretEn = 1'b0;
    rd("mret_mstatus", ADDR_MSTATUS, 32'h0000_1888);

    // Illegal accesses leave state alone.
    op = OP_WRITE; a = ADDR_CYCLE; di = 32'h0;
    pushExp("ill_cycle_flag", 32'h1); #1; checkObs({31'd0, illegal});
    pushExp("ill_cycle_read", cycModel[31:0]); #1; checkObs(dout);
    tick();
    rd("cycle_keeps_counting", ADDR_CYCLE, cycModel[31:0]);
    op = OP_WRITE; a = 12'h7FF;
    pushExp("ill_unknown_flag", 32'h1); #1; checkObs({31'd0, illegal});
    pushExp("ill_unknown_read", 32'h0); #1; checkObs(dout);
    op = OP_NONE;
    pushExp("unknown_read_ok", 32'h0); #1; checkObs({31'd0, illegal});
    op = OP_WRITE; a = ADDR_MIP;
    pushExp("mip_write_legal", 32'h0); #1; checkObs({31'd0, illegal});
    op = OP_NONE;
    wr(OP_WRITE, ADDR_MTVEC, 32'h0000_2003);
    rd("mtvec_mode3_kept", ADDR_MTVEC, 32'h0000_2001);

    // Trap beats a same-cycle mepc write; other CSR writes still land.
    op = OP_WRITE; a = ADDR_MEPC; di = 32'h40;
    trapEn = 1'b1; trapPc = 32'h80; trapCause = 32'h2;
    tick();
    op = OP_NONE; trapEn = 1'b0;
    pushExp("trap_over_mepc_write", 32'h80); #1; checkObs(mepcDo);
    rd("trap_mcause2", ADDR_MCAUSE, 32'h2);
    op = OP_WRITE; a = ADDR_MSCRATCH; di = 32'hDEAD_BEEF;
    trapEn = 1'b1; trapPc = 32'h100;
    tick();
    op = OP_NONE; trapEn = 1'b0;
    rd("mscratch_with_trap", ADDR_MSCRATCH, 32'hDEAD_BEEF);
    wr(OP_WRITE, ADDR_MEPC, 32'h43);
    pushExp("mepc_align", 32'h40); #1; checkObs(mepcDo);

    // Asynchronous reset mid-run.
    reset = 1'b1;
    #1;
    pushExp("areset_mepcDo", 32'h0); #1; checkObs(mepcDo);
    rd("areset_mtvec", ADDR_MTVEC, 32'h0000_2000);
    rd("areset_mscratch", ADDR_MSCRATCH, 32'h0);
    rd("areset_mstatus", ADDR_MSTATUS, 32'h0000_1800);
    rd("areset_mcycle", ADDR_MCYCLE, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_machine.md
# csr_machine

Parametrised machine-mode CSR unit: the successor to the basic trap CSR block. It adds interrupt enable/pending, `mstatus` MIE/MPIE stacking, 64-bit-capable cycle/instret counters, read-modify-write ops, illegal-access flagging and vectored trap-target computation. It sits beside the register file in the execute stage. The core uses its outputs to redirect the PC on traps and `mret`.

## Interface
- `MTVEC_RESET`, default 32'h0: reset value of `mtvec`; bits [1:0] are forced to a legal mode.
- `COUNTER_W`, default 64: width of `mcycle`/`minstret` (32..64); bits at and above `COUNTER_W` read 0.
- `VECTORED_EN`, default 1: 1 permits `mtvec` mode 1; 0 hard-wires mode to 0.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `op`  in  2  00 none, 01 write, 10 set bits, 11 clear bits.
- `a`  in  12  CSR address.
- `di`  in  32  write data or mask.
- `do`  out  32  old CSR value, combinational.
- `illegal`  out  1  combinational; unknown address, or `op`≠00 to a read-only address.
- `retire`  in  1  one instruction retired this cycle.
- `trapEn`  in  1  take trap this cycle.
- `trapCause`  in  32  `mcause` value; bit 31 marks an interrupt.
- `trapPc`  in  32  PC saved to `mepc`.
- `mretEn`  in  1  execute `mret` this cycle.
- `irqExt`, `irqTimer`, `irqSw`  in  1 each  level interrupt lines.
- `mepcDo`  out  32  current `mepc`.
- `trapVector`  out  32  trap target for the current `trapCause`.
- `irqPending`  out  1  an enabled interrupt is pending and globally enabled.
- `irqCause`  out  32  cause for the highest-priority pending interrupt.

## Operation
- Implemented CSRs:
  - `misa` 0x301: constant 0x40000100.
  - `mstatus` 0x300: MIE bit3, MPIE bit7, MPP [12:11] read 2'b11, all other bits 0.
  - `mie` 0x304: bits 3/7/11 writable, rest 0.
  - `mip` 0x344: read-only view of irq lines at bits 3/7/11; writes to it are ignored and not illegal.
  - `mtvec` 0x305, `mscratch` 0x340, `mepc` 0x341 (bits [1:0] forced 0), `mcause` 0x342.
  - Counters: `mcycle` 0xB00, `mcycleh` 0xB80, `minstret` 0xB02, `minstreth` 0xB82.
  - Read-only shadows: `cycle`/`cycleh`/`instret`/`instreth` at 0xC00/0xC80/0xC02/0xC82.
- Any other address: `do`=0, `illegal`=1 when `op`≠00. An illegal access never updates state.
- New value for a write op: write gives `di`, set gives `old|di`, clear gives `old&~di`. The op is committed at the rising edge.
- `mtvec` MODE write of 2 or 3, or of 1 with `VECTORED_EN`=0, keeps the previous MODE; BASE is always written.
- Counters:
  - `mcycle` +1 every cycle; `minstret` +1 when `retire`=1. Both wrap at 2^`COUNTER_W`.
  - A CSR write to either half of a counter replaces that half and suppresses that counter's increment for that cycle.
- Trap (`trapEn`=1):
  - `mepc`←`trapPc`, `mcause`←`trapCause`, MPIE←MIE, MIE←0.
  - Takes priority over a same-cycle CSR write or `mret` for `mepc`, `mcause` and `mstatus`. CSR writes to other registers still commit.
- `mret` (`mretEn`=1, `trapEn`=0): MIE←MPIE, MPIE←1.
- `irqPending` = MIE & |(`mie` & `mip`).
  - Priority: external (cause 0x8000000B) > software (0x80000003) > timer (0x80000007). This sets `irqCause`.
  - If nothing is pending, `irqCause` = 0.
- `trapVector` = {BASE,2'b00}, plus 4×`trapCause`[30:0] when MODE=1 and `trapCause`[31]=1.

## Timing
- Reads, `illegal`, `irqPending`, `irqCause` and `trapVector` are combinational, with zero latency.
- All state updates land on the rising edge and are visible in the cycle after.
- A read of a counter returns its pre-increment value; the same-cycle increment is visible next cycle.
- Reset (asynchronous, any time, including mid-trap):
  - All registers clear to 0, except `mtvec` = `MTVEC_RESET` with MODE legalised.
  - Resulting values: `do` follows the address (`mstatus` reads 0x1800), `irqPending`=0, `mepcDo`=0.
- The first increment after reset release occurs at the first rising edge with `reset`=0.

## Structure
- Package `csr_pkg`:
  - CSR address constants and the `op` encoding enum.
  - `mstatus`/`mie` bit indices and interrupt cause codes.
  - The `misa` constant.
- Sub-module `csr_counter` (parameter `COUNTER_W`):
  - Inputs: `inc`, `weLo`, `weHi`, `di`.
  - Outputs: `lo`/`hi` 32-bit read halves.
  - Instantiated twice, for cycle and instret.

## Test plan
- Reset, then idle 5 cycles → `mstatus` reads 0x1800, `mcycle` reads 5, `minstret` reads 0, `mtvec` = `MTVEC_RESET`.
- Write 0xFFFFFFFF to `mcycle`, then read `mcycleh` two cycles later → 1; `mcycle` reads 0x00000001.
- Set MIE via `op`=10 on 0x300 with `di`=0x8, `mie`=0x880, `irqTimer`=1 → `irqPending`=1 and `irqCause`=0x80000007; additionally assert `irqExt` → `irqCause`=0x8000000B.
- `mtvec`=0x1001, `trapEn` with `trapCause`=0x80000007 → `trapVector`=0x101C. Next cycle MIE=0, MPIE=1, `mepc`=`trapPc`. Then `mret` → MIE=1.
- `op`=01 to 0xC00, and to 0x7FF → `illegal`=1 and `cycle` keeps counting. Write `mtvec` MODE=3 → MODE unchanged.
- Same-cycle `trapEn` and CSR write of `mepc`=0x40 with `trapPc`=0x80 → `mepc`=0x80.
